zbb_count_unit: RTL and testbench



---
 rtl/zbb_pkg.sv | 24 ++
 rtl/zbb_lzc32.sv | 40 ++++
 rtl/zbb_count_unit.sv | 159 +++++++++++++++
 tb/tb_zbb_count_unit.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/zbb_pkg.sv
// Shared definitions for the Zbb count execute stage: op encodings, widths
// and the operand bit-reverse used to turn CTZ into a leading-zero count.
package zbb_pkg;

    localparam int XLEN  = 32;
    localparam int CNT_W = 6;

    typedef enum logic [1:0] {
        ZBB_OP_CLZ  = 2'b00,
        ZBB_OP_CTZ  = 2'b01,
        ZBB_OP_CPOP = 2'b10,
        ZBB_OP_RSVD = 2'b11
    } zbb_op_e;

    function automatic logic [XLEN-1:0] bit_reverse(input logic [XLEN-1:0] value);
        logic [XLEN-1:0] reversed;
        reversed = '0;
        for (int i = 0; i < XLEN; i++) begin
            reversed[i] = value[XLEN-1-i];
        end
        return reversed;
    endfunction

endpackage

// File: rtl/zbb_lzc32.sv
// Combinational 32-bit leading-zero counter; an all-zero operand yields 32.
module zbb_lzc32 (
    input  logic [31:0] operand,
    output logic [5:0]  count
);

    logic [7:0] nib_zero;
    logic [1:0] nib_cnt [8];

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_nibble
            logic [3:0] nib;
            assign nib          = operand[4*gi+3 : 4*gi];
            assign nib_zero[gi] = (nib == 4'd0);
            always_comb begin
                if (nib[3]) begin
                    nib_cnt[gi] = 2'd0;
                end else if (nib[2]) begin
                    nib_cnt[gi] = 2'd1;
                end else if (nib[1]) begin
                    nib_cnt[gi] = 2'd2;
                end else begin
                    nib_cnt[gi] = 2'd3;
                end
            end
        end
    endgenerate

    // Scan upwards so the most significant non-zero nibble has the last word.
    always_comb begin
        count = 6'd32;
        for (int i = 0; i < 8; i++) begin
            if (!nib_zero[i]) begin
                count = {1'b0, 3'(7 - i), nib_cnt[i]};
            end
        end
    end

endmodule

// File: rtl/zbb_count_unit.sv
// Two-stage CLZ/CTZ/CPOP execute unit with valid/ready on both sides.
// S1 holds the conditioned operand, S2 holds the zero-extended count.
module zbb_count_unit
    import zbb_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      in_op,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [4:0]      in_rd,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [4:0]      out_rd,
    output logic [XLEN-1:0] out_result
);

    logic             s1_valid_q, s1_valid_d;
    zbb_op_e          s1_op_q, s1_op_d;
    logic [XLEN-1:0]  s1_opnd_q, s1_opnd_d;
    logic [4:0]       s1_rd_q, s1_rd_d;

    logic             s2_valid_q, s2_valid_d;
    logic [CNT_W-1:0] s2_result_q, s2_result_d;
    logic [4:0]       s2_rd_q, s2_rd_d;

    logic             s2_adv;
    logic             s1_adv;
    logic             accept;
    zbb_op_e          in_op_e;

    assign in_op_e  = zbb_op_e'(in_op);
    assign s2_adv   = !s2_valid_q || out_ready;
    assign in_ready = !s1_valid_q || s2_adv;
    assign s1_adv   = s1_valid_q && s2_adv;
    // A flush cycle never accepts, even while in_ready is high.
    assign accept   = in_valid && in_ready && !flush;

    // ---------------- compute between S1 and S2 ----------------
    logic [5:0] lzc_cnt;

    zbb_lzc32 u_lzc (
        .operand (s1_opnd_q),
        .count   (lzc_cnt)
    );

    logic [1:0] pop_l1 [16];
    logic [2:0] pop_l2 [8];
    logic [3:0] pop_l3 [4];
    logic [4:0] pop_l4 [2];
    logic [5:0] pop_sum;

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_pop_l1
            assign pop_l1[gi] = {1'b0, s1_opnd_q[2*gi]} + {1'b0, s1_opnd_q[2*gi+1]};
        end
        for (gi = 0; gi < 8; gi++) begin : g_pop_l2
            assign pop_l2[gi] = {1'b0, pop_l1[2*gi]} + {1'b0, pop_l1[2*gi+1]};
        end
        for (gi = 0; gi < 4; gi++) begin : g_pop_l3
            assign pop_l3[gi] = {1'b0, pop_l2[2*gi]} + {1'b0, pop_l2[2*gi+1]};
        end
        for (gi = 0; gi < 2; gi++) begin : g_pop_l4
            assign pop_l4[gi] = {1'b0, pop_l3[2*gi]} + {1'b0, pop_l3[2*gi+1]};
        end
    endgenerate

    assign pop_sum = {1'b0, pop_l4[0]} + {1'b0, pop_l4[1]};

    logic [CNT_W-1:0] compute_result;

    always_comb begin
        compute_result = '0;
        case (s1_op_q)
            ZBB_OP_CLZ,
            ZBB_OP_CTZ:  compute_result = lzc_cnt;
            ZBB_OP_CPOP: compute_result = pop_sum;
            default:     compute_result = '0;
        endcase
    end

    // ---------------- next-state ----------------
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_op_d    = s1_op_q;
        s1_opnd_d  = s1_opnd_q;
        s1_rd_d    = s1_rd_q;

        if (flush) begin
            s1_valid_d = 1'b0;
        end else if (accept) begin
            s1_valid_d = 1'b1;
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end

        if (accept) begin
            s1_op_d   = in_op_e;
            s1_rd_d   = in_rd;
            s1_opnd_d = (in_op_e == ZBB_OP_CTZ) ? bit_reverse(in_rs1) : in_rs1;
        end
    end

    always_comb begin
        s2_valid_d  = s2_valid_q;
        s2_result_d = s2_result_q;
        s2_rd_d     = s2_rd_q;

        if (flush) begin
            s2_valid_d = 1'b0;
        end else if (s2_adv) begin
            s2_valid_d = s1_valid_q;
        end

        // Data only moves with a real op so an idle S2 keeps its last value.
        if (s1_adv) begin
            s2_result_d = compute_result;
            s2_rd_d     = s1_rd_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_op_q     <= ZBB_OP_CLZ;
            s1_opnd_q   <= '0;
            s1_rd_q     <= '0;
            s2_valid_q  <= 1'b0;
            s2_result_q <= '0;
            s2_rd_q     <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_op_q     <= s1_op_d;
            s1_opnd_q   <= s1_opnd_d;
            s1_rd_q     <= s1_rd_d;
            s2_valid_q  <= s2_valid_d;
            s2_result_q <= s2_result_d;
            s2_rd_q     <= s2_rd_d;
        end
    end

    assign out_valid  = s2_valid_q;
    assign out_rd     = s2_rd_q;
    assign out_result = {{(XLEN-CNT_W){1'b0}}, s2_result_q};

`ifndef SYNTHESIS
    // A stalled result must stay put until taken, flushed or reset.
    a_out_hold: assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready && !flush) |=>
            (out_valid && $stable(out_rd) && $stable(out_result)));
`endif

endmodule

// File: tb/tb_zbb_count_unit.sv
// Directed bench for zbb_count_unit: latency, count boundaries, streaming,
// stall/release, flush and reset-during-stall behaviour.
module tb_zbb_count_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_op = 2'b00;
    logic [31:0] in_rs1 = 32'd0;
    logic [4:0]  in_rd = 5'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [4:0]  out_rd;
    logic [31:0] out_result;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    zbb_count_unit dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_rs1     (in_rs1),
        .in_rd      (in_rd),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_rd     (out_rd),
        .out_result (out_result)
    );

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checks += 4;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        if (out_rd !== 5'd0) begin failures++; $display("FAIL reset_out_rd got=%0d want=0", out_rd); end
        if (out_result !== 32'd0) begin failures++; $display("FAIL reset_out_result got=%h want=0", out_result); end
        if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_idle_valid got=%b want=0", out_valid); end
        $display("reset: done");
    endtask

    // Single CLZ first to pin the latency, then the boundary vectors streamed.
    task automatic test_count_ops();
        logic [1:0]  op_tab  [8];
        logic [31:0] rs1_tab [8];
        logic [4:0]  rd_tab  [8];
        logic [31:0] exp_tab [8];
        logic        exp_v;
        op_tab  = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b11, 2'b00};
        rs1_tab = '{32'h0001_0000, 32'h0000_0000, 32'h8000_0000, 32'hFFFF_FFFF,
                    32'hF0F0_00FF, 32'hFFFF_FFFF, 32'h1234_5678, 32'h0000_0000};
        rd_tab  = '{5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11, 5'd12};
        exp_tab = '{32'd15, 32'd32, 32'd31, 32'd0, 32'd16, 32'd32, 32'd0, 32'd32};
        out_ready = 1'b1;
        // First op alone: t=0 drive, valid must appear exactly at t=2.
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            exp_v = (t == 2);
            checks++;
            if (out_valid !== exp_v) begin failures++; $display("FAIL clz_latency[t=%0d] out_valid got=%b want=%b", t, out_valid, exp_v); end
            if (t == 2) begin
                checks += 2;
                if (out_result !== 32'd15) begin failures++; $display("FAIL clz_result got=%0d want=15", out_result); end
                if (out_rd !== 5'd5) begin failures++; $display("FAIL clz_rd got=%0d want=5", out_rd); end
            end
            in_valid = (t == 0);
            in_op = op_tab[0]; in_rs1 = rs1_tab[0]; in_rd = rd_tab[0];
        end
        $display("count_ops: single CLZ latency checked");
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            exp_v = (t >= 2 && t < 9);
            checks += 2;
            if (in_ready !== 1'b1) begin failures++; $display("FAIL count_ops[t=%0d] in_ready got=%b want=1", t, in_ready); end
            if (out_valid !== exp_v) begin failures++; $display("FAIL count_ops[t=%0d] out_valid got=%b want=%b", t, out_valid, exp_v); end
            if (exp_v) begin
                checks += 2;
                if (out_result !== exp_tab[t-1]) begin failures++; $display("FAIL count_ops[%0d] out_result got=%0d want=%0d", t-1, out_result, exp_tab[t-1]); end
                if (out_rd !== rd_tab[t-1]) begin failures++; $display("FAIL count_ops[%0d] out_rd got=%0d want=%0d", t-1, out_rd, rd_tab[t-1]); end
                $display("count_ops: rd=%0d result=%0d", out_rd, out_result);
            end
            in_valid = (t < 7);
            if (t < 7) begin
                in_op = op_tab[t+1]; in_rs1 = rs1_tab[t+1]; in_rd = rd_tab[t+1];
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0]  op_tab  [8];
        logic [31:0] rs1_tab [8];
        logic [4:0]  rd_tab  [8];
        logic [31:0] exp_tab [8];
        logic        exp_v;
        op_tab  = '{2'b00, 2'b01, 2'b10, 2'b01, 2'b00, 2'b10, 2'b01, 2'b10};
        rs1_tab = '{32'h0000_0001, 32'h0000_0001, 32'h0000_000F, 32'h0000_0100,
                    32'h0080_0000, 32'hAAAA_AAAA, 32'hFFFF_0000, 32'h8000_0001};
        rd_tab  = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd31};
        exp_tab = '{32'd31, 32'd0, 32'd4, 32'd8, 32'd8, 32'd16, 32'd16, 32'd2};
        out_ready = 1'b1;
        for (int t = 0; t < 11; t++) begin
            @(negedge clk);
            exp_v = (t >= 2 && t < 10);
            checks += 2;
            if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b[t=%0d] in_ready got=%b want=1", t, in_ready); end
            if (out_valid !== exp_v) begin failures++; $display("FAIL b2b[t=%0d] out_valid got=%b want=%b", t, out_valid, exp_v); end
            if (exp_v) begin
                checks += 2;
                if (out_result !== exp_tab[t-2]) begin failures++; $display("FAIL b2b[%0d] out_result got=%0d want=%0d", t-2, out_result, exp_tab[t-2]); end
                if (out_rd !== rd_tab[t-2]) begin failures++; $display("FAIL b2b[%0d] out_rd got=%0d want=%0d", t-2, out_rd, rd_tab[t-2]); end
                $display("b2b: rd=%0d result=%0d", out_rd, out_result);
            end
            in_valid = (t < 8);
            if (t < 8) begin
                in_op = op_tab[t]; in_rs1 = rs1_tab[t]; in_rd = rd_tab[t];
            end
        end
    endtask

    // A=CLZ 0x10 ->27, B=CTZ 0x40 ->6, C=CPOP 0xFFFF ->16; out_ready low for 5 edges.
    task automatic test_stall();
        logic        v_tab   [9];
        logic [4:0]  rd_tab  [9];
        logic [31:0] res_tab [9];
        logic        rdy_tab [9];
        v_tab   = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        rd_tab  = '{5'd0, 5'd0, 5'd12, 5'd12, 5'd12, 5'd12, 5'd13, 5'd14, 5'd0};
        res_tab = '{32'd0, 32'd0, 32'd27, 32'd27, 32'd27, 32'd27, 32'd6, 32'd16, 32'd0};
        rdy_tab = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            checks += 2;
            if (out_valid !== v_tab[k]) begin failures++; $display("FAIL stall[k=%0d] out_valid got=%b want=%b", k, out_valid, v_tab[k]); end
            if (in_ready !== rdy_tab[k]) begin failures++; $display("FAIL stall[k=%0d] in_ready got=%b want=%b", k, in_ready, rdy_tab[k]); end
            if (v_tab[k]) begin
                checks += 2;
                if (out_rd !== rd_tab[k]) begin failures++; $display("FAIL stall[k=%0d] out_rd got=%0d want=%0d", k, out_rd, rd_tab[k]); end
                if (out_result !== res_tab[k]) begin failures++; $display("FAIL stall[k=%0d] out_result got=%0d want=%0d", k, out_result, res_tab[k]); end
                $display("stall: k=%0d rd=%0d result=%0d ready=%b", k, out_rd, out_result, out_ready);
            end
            case (k)
                0: begin out_ready = 1'b0; in_valid = 1'b1; in_op = 2'b00; in_rs1 = 32'h0000_0010; in_rd = 5'd12; end
                1: begin in_op = 2'b01; in_rs1 = 32'h0000_0040; in_rd = 5'd13; end
                2: begin in_op = 2'b10; in_rs1 = 32'h0000_FFFF; in_rd = 5'd14; end
                5: begin
                    out_ready = 1'b1;
                    #1;
                    checks++;
                    if (in_ready !== 1'b1) begin failures++; $display("FAIL stall_release in_ready got=%b want=1", in_ready); end
                end
                6: in_valid = 1'b0;
                default: ;
            endcase
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; in_op = 2'b00; in_rs1 = 32'h0000_0001; in_rd = 5'd20;
        @(negedge clk);
        in_op = 2'b10; in_rs1 = 32'h0000_0003; in_rd = 5'd21;
        @(negedge clk);
        checks += 2;
        if (out_valid !== 1'b1) begin failures++; $display("FAIL flush_full out_valid got=%b want=1", out_valid); end
        if (in_ready !== 1'b0) begin failures++; $display("FAIL flush_full in_ready got=%b want=0", in_ready); end
        in_op = 2'b01; in_rs1 = 32'h0000_0008; in_rd = 5'd22; flush = 1'b1;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            checks += 2;
            if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_full[k=%0d] out_valid got=%b want=0 rd=%0d", k, out_valid, out_rd); end
            if (in_ready !== 1'b1) begin failures++; $display("FAIL flush_full[k=%0d] in_ready got=%b want=1", k, in_ready); end
            @(negedge clk);
        end
        $display("flush: full pipeline discarded");
        // Empty pipe: in_ready is high during flush but the op must not be taken.
        in_valid = 1'b1; in_op = 2'b10; in_rs1 = 32'hFFFF_FFFF; in_rd = 5'd23; flush = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL flush_empty in_ready got=%b want=1", in_ready); end
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_empty[k=%0d] out_valid got=%b want=0 rd=%0d", k, out_valid, out_rd); end
            @(negedge clk);
        end
        $display("flush: op offered during flush not accepted");
    endtask

    task automatic test_reset_mid_stall();
        out_ready = 1'b0;
        in_valid = 1'b1; in_op = 2'b00; in_rs1 = 32'h0000_0100; in_rd = 5'd25;
        @(negedge clk);
        in_op = 2'b10; in_rs1 = 32'h0000_00FF; in_rd = 5'd26;
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1) begin failures++; $display("FAIL rst_stall_full out_valid got=%b want=1", out_valid); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks += 4;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_stall out_valid got=%b want=0", out_valid); end
        if (out_rd !== 5'd0) begin failures++; $display("FAIL rst_stall out_rd got=%0d want=0", out_rd); end
        if (out_result !== 32'd0) begin failures++; $display("FAIL rst_stall out_result got=%0d want=0", out_result); end
        if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_stall in_ready got=%b want=1", in_ready); end
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_stall_drain[k=%0d] out_valid got=%b want=0", k, out_valid); end
        end
        $display("reset_mid_stall: in-flight ops discarded");
    endtask

    initial begin
        test_reset();
        test_count_ops();
        test_back_to_back();
        test_stall();
        test_flush();
        test_reset_mid_stall();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
